pe_row_feeder: RTL and testbench



---
 rtl/pe_pkg.sv | 20 ++
 rtl/row_bank.sv | 43 ++++
 rtl/pe_row_feeder.sv | 138 +++++++++++++
 tb/tb_pe_row_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE row feeder and its banks.
package pe_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned FILT_LEN_DEF = 3;
  localparam int unsigned IMAP_LEN_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_PE,
    SEND,
    DONE
  } feeder_state_t;

  localparam logic [1:0] SEL_WEIGHT = 2'd0;
  localparam logic [1:0] SEL_IMAP   = 2'd1;
  localparam logic [1:0] SEL_PSUM   = 2'd2;

endpackage

// File: rtl/row_bank.sv
// DEPTH x DATA_W register file filled in order by a write counter.
// Reads past the filled depth return zero so short banks pad the stream.
module row_bank #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  count,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign full = (count == IDX_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (count == IDX_W'(i)) mem[i] <= wr_data;
      count <= count + IDX_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/pe_row_feeder.sv
// Buffers one convolution row and streams it into the PE.
// FEEDER_WEIGHT_REUSE_EN: weights persist across rows until reset.
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned FILT_LEN = FILT_LEN_DEF,
  parameter int unsigned IMAP_LEN = IMAP_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              from_pe_ready,
  output logic              to_pe_enable,
  output logic [DATA_W-1:0] to_pe_weight_value,
  output logic [DATA_W-1:0] to_pe_imap_value,
  output logic [DATA_W-1:0] to_pe_psum_value,
  output logic              row_done,
  output logic              wr_err
);

  localparam int unsigned OUT_LEN = IMAP_LEN - FILT_LEN + 1;
  localparam int unsigned IDX_W   = $clog2(IMAP_LEN + 1);

  feeder_state_t     state;
  logic [IDX_W-1:0]  k;
  logic [IDX_W-1:0]  rd_idx;
  logic              accept, bad_wr, loaded;
  logic              w_we, i_we, p_we;
  logic              w_full, i_full, p_full;
  logic              bank_clr, w_clr;
  logic [IDX_W-1:0]  w_cnt, i_cnt, p_cnt;
  logic [DATA_W-1:0] w_rd, i_rd, p_rd;

  assign accept = wr_valid && wr_ready;

  always_comb begin
    w_we   = accept && (wr_sel == SEL_WEIGHT) && !w_full;
    i_we   = accept && (wr_sel == SEL_IMAP)   && !i_full;
    p_we   = accept && (wr_sel == SEL_PSUM)   && !p_full;
    bad_wr = accept && ((wr_sel == 2'd3) ||
                        ((wr_sel == SEL_WEIGHT) && w_full) ||
                        ((wr_sel == SEL_IMAP)   && i_full) ||
                        ((wr_sel == SEL_PSUM)   && p_full));
    // Completion is judged on the counts including this cycle's write.
    loaded = ((w_cnt + IDX_W'(w_we)) == IDX_W'(FILT_LEN)) &&
             ((i_cnt + IDX_W'(i_we)) == IDX_W'(IMAP_LEN)) &&
             ((p_cnt + IDX_W'(p_we)) == IDX_W'(OUT_LEN));
  end

  // The bus registers load the next word, so read one ahead of k.
  assign rd_idx   = (state == SEND) ? (k + IDX_W'(1)) : '0;
  assign bank_clr = (state == DONE);

`ifdef FEEDER_WEIGHT_REUSE_EN
  assign w_clr = 1'b0;
`else
  assign w_clr = bank_clr;
`endif

  row_bank #(.DEPTH(FILT_LEN), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_weight (
    .clk(clk), .rst(rst), .clr(w_clr), .wr_en(w_we), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(w_rd), .count(w_cnt), .full(w_full)
  );

  row_bank #(.DEPTH(IMAP_LEN), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_imap (
    .clk(clk), .rst(rst), .clr(bank_clr), .wr_en(i_we), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(i_rd), .count(i_cnt), .full(i_full)
  );

  row_bank #(.DEPTH(OUT_LEN), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_psum (
    .clk(clk), .rst(rst), .clr(bank_clr), .wr_en(p_we), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(p_rd), .count(p_cnt), .full(p_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      k                  <= '0;
      wr_ready           <= 1'b0;
      to_pe_enable       <= 1'b0;
      to_pe_weight_value <= '0;
      to_pe_imap_value   <= '0;
      to_pe_psum_value   <= '0;
      row_done           <= 1'b0;
      wr_err             <= 1'b0;
    end else begin
      if (bad_wr) wr_err <= 1'b1;
      to_pe_enable <= 1'b0;
      row_done     <= 1'b0;
      case (state)
        IDLE: begin
          state    <= LOAD;
          wr_ready <= 1'b1;
        end
        LOAD: begin
          if (loaded) begin
            state    <= WAIT_PE;
            wr_ready <= 1'b0;
          end
        end
        WAIT_PE: begin
          if (from_pe_ready) begin
            state              <= SEND;
            k                  <= '0;
            to_pe_enable       <= 1'b1;
            to_pe_weight_value <= w_rd;
            to_pe_imap_value   <= i_rd;
            to_pe_psum_value   <= p_rd;
          end
        end
        SEND: begin
          if (k == IDX_W'(IMAP_LEN - 1)) begin
            state              <= DONE;
            row_done           <= 1'b1;
            to_pe_weight_value <= '0;
            to_pe_imap_value   <= '0;
            to_pe_psum_value   <= '0;
          end else begin
            k                  <= k + IDX_W'(1);
            to_pe_weight_value <= w_rd;
            to_pe_imap_value   <= i_rd;
            to_pe_psum_value   <= p_rd;
          end
        end
        DONE: begin
          state <= IDLE;
          k     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Scoreboard bench for pe_row_feeder: stimulus queues expected stream beats,
// a monitor pops and compares them whenever the DUT streams a row.
module tb_pe_row_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        from_pe_ready;
  logic        to_pe_enable;
  logic [31:0] to_pe_weight_value;
  logic [31:0] to_pe_imap_value;
  logic [31:0] to_pe_psum_value;
  logic        row_done;
  logic        wr_err;

  typedef struct {
    logic        en;
    logic [31:0] w;
    logic [31:0] i;
    logic [31:0] p;
    logic        done;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    phase = 0;

  pe_row_feeder #(.DATA_W(32), .FILT_LEN(3), .IMAP_LEN(5)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .from_pe_ready(from_pe_ready),
    .to_pe_enable(to_pe_enable), .to_pe_weight_value(to_pe_weight_value),
    .to_pe_imap_value(to_pe_imap_value), .to_pe_psum_value(to_pe_psum_value),
    .row_done(row_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Six beats per row: five streamed words, then the DONE cycle.
  task automatic push_row(input int wb, input int ib, input int pb);
    beat_t b;
    for (int k = 0; k < 5; k++) begin
      b.en   = (k == 0);
      b.w    = (k < 3) ? 32'(wb + k) : 32'd0;
      b.i    = 32'(ib + k);
      b.p    = (k < 3 && pb != 0) ? 32'(pb + k) : 32'd0;
      b.done = 1'b0;
      q.push_back(b);
    end
    b.en = 1'b0; b.w = '0; b.i = '0; b.p = '0; b.done = 1'b1;
    q.push_back(b);
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    int t;
    bit acc;
    @(negedge clk);
    wr_valid = 1'b1; wr_sel = s; wr_data = d;
    t = 0; acc = 1'b0;
    while (!acc && t < 100) begin
      @(posedge clk);
      acc = wr_ready;
      t++;
    end
    #1 wr_valid = 1'b0;
    if (!acc) timeout("wr_handshake");
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_row(input int wb, input int ib, input int pb, input bit with_w);
    if (with_w) for (int k = 0; k < 3; k++) wr(2'd0, 32'(wb + k));
    for (int k = 0; k < 5; k++) wr(2'd1, 32'(ib + k));
    for (int k = 0; k < 3; k++) wr(2'd2, (pb != 0) ? 32'(pb + k) : 32'd0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || phase != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) timeout("row_stream");
    @(posedge clk);
  endtask

  // Monitor: a stream starts on enable and spans six sampled cycles.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        phase = 0;
      end else begin
        if (phase == 0 && to_pe_enable) phase = 6;
        if (phase > 0) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_stream: enable=%0b with empty scoreboard", to_pe_enable);
            phase = 0;
          end else begin
            e = q.pop_front();
            chk("enable", 32'(to_pe_enable), 32'(e.en));
            chk("weight", to_pe_weight_value, e.w);
            chk("imap", to_pe_imap_value, e.i);
            chk("psum", to_pe_psum_value, e.p);
            chk("row_done", 32'(row_done), 32'(e.done));
            phase--;
          end
        end else if (row_done) begin
          chk("spurious_row_done", 32'(row_done), 32'd0);
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; from_pe_ready = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_enable", 32'(to_pe_enable), 32'd0);
    chk("rst_weight", to_pe_weight_value, 32'd0);
    chk("rst_imap", to_pe_imap_value, 32'd0);
    chk("rst_psum", to_pe_psum_value, 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    gap(2);
    rst = 1'b1;

    // Basic row with ready held high.
    from_pe_ready = 1'b1;
    push_row(1, 10, 100);
    load_row(1, 10, 100, 1'b1);
    wait_idle();

    // Interleaved order with valid gaps.
    push_row(1, 10, 100);
    wr(2'd1, 32'd10); wr(2'd2, 32'd100); gap(2);
    wr(2'd0, 32'd1);  wr(2'd1, 32'd11);  wr(2'd1, 32'd12); gap(3);
    wr(2'd0, 32'd2);  wr(2'd2, 32'd101); wr(2'd1, 32'd13);
    wr(2'd0, 32'd3);  gap(1);
    wr(2'd2, 32'd102); wr(2'd1, 32'd14);
    wait_idle();
    chk("interleave_wr_err", 32'(wr_err), 32'd0);

    // Overflowing weight write and reserved select are dropped.
    push_row(1, 10, 100);
    for (int k = 0; k < 3; k++) wr(2'd0, 32'(1 + k));
    wr(2'd0, 32'd99);
    wr(2'd3, 32'd77);
    @(posedge clk); #1;
    chk("overflow_wr_err", 32'(wr_err), 32'd1);
    load_row(0, 10, 100, 1'b0);
    wait_idle();
    chk("overflow_err_sticky", 32'(wr_err), 32'd1);

    // Ready withheld for 20 cycles after the load completes.
    from_pe_ready = 1'b0;
    push_row(1, 10, 100);
    load_row(1, 10, 100, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("withheld_enable", 32'(to_pe_enable), 32'd0);
    end
    chk("withheld_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    from_pe_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_to_enable", 32'(to_pe_enable), 32'd1);
    wait_idle();
    chk("withheld_err_sticky", 32'(wr_err), 32'd1);

    // Reset at SEND k=2 aborts the stream without row_done.
    push_row(1, 10, 100);
    load_row(1, 10, 100, 1'b1);
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (!to_pe_enable && t < 100);
    if (!to_pe_enable) timeout("mid_send_enable");
    repeat (2) begin
      @(posedge clk); #2;
    end
    chk("mid_send_k2_imap", to_pe_imap_value, 32'd12);
    rst = 1'b0;
    #1;
    chk("abort_enable", 32'(to_pe_enable), 32'd0);
    chk("abort_weight", to_pe_weight_value, 32'd0);
    chk("abort_imap", to_pe_imap_value, 32'd0);
    chk("abort_psum", to_pe_psum_value, 32'd0);
    chk("abort_row_done", 32'(row_done), 32'd0);
    chk("abort_wr_err", 32'(wr_err), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("post_abort_row_done", 32'(row_done), 32'd0);
    end
    push_row(1, 10, 100);
    load_row(1, 10, 100, 1'b1);
    wait_idle();

`ifdef FEEDER_WEIGHT_REUSE_EN
    // Weights retained: reload only imap and psum; a weight write is dropped.
    push_row(1, 20, 0);
    wr(2'd0, 32'd5);
    @(posedge clk); #1;
    chk("reuse_weight_wr_err", 32'(wr_err), 32'd1);
    load_row(0, 20, 0, 1'b0);
    wait_idle();
`endif

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
